// File: rtl/pcie_dl_tx_arb_if.sv
// pcie_dl_tx_arb_if: AXI-Stream bundle between the datalink sources, the tx arbiter and the PHY
// Signals:
//   s_axis_*  S_COUNT packed input streams, port 0 in the LSBs; s_axis_tready driven by the arbiter
//   m_axis_*  single output stream driven by the arbiter; m_axis_tready driven by the sink
// Modports:
//   slave   arbiter view (consumes s_axis_*, produces m_axis_*)
//   master  environment view (produces s_axis_*, consumes m_axis_*)
interface pcie_dl_tx_arb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = 3,
   parameter int S_COUNT = 3
);
   logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
   logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep;
   logic [S_COUNT-1:0] s_axis_tvalid;
   logic [S_COUNT-1:0] s_axis_tlast;
   logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser;
   logic [S_COUNT-1:0] s_axis_tready;
   logic [DATA_WIDTH-1:0] m_axis_tdata;
   logic [KEEP_WIDTH-1:0] m_axis_tkeep;
   logic m_axis_tvalid;
   logic m_axis_tlast;
   logic [USER_WIDTH-1:0] m_axis_tuser;
   logic m_axis_tready;
   modport slave (
      input s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      input m_axis_tready
   );
   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      input s_axis_tready,
      input m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      output m_axis_tready
   );
endinterface

// File: rtl/pcie_dl_tx_arb.sv
// pcie_dl_tx_arb: packet-atomic DLLP/TLP transmit arbiter with a single registered output stage
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   bus             slave side of pcie_dl_tx_arb_if (S_COUNT AXIS inputs, one AXIS output)
//   link_up_i       DL_Active; low blocks new TLP-class grants
//   grant_o         index of the currently granted port
//   grant_vld_o     a packet is currently granted
//   stat_pkt_cnt_o  per-port 16-bit wrapping tlast counters      (PCIE_DL_TX_ARB_STATS_EN)
//   stat_starve_o   1-cycle pulse on a starvation-forced grant    (PCIE_DL_TX_ARB_STATS_EN)
// Optional statistics are built only when PCIE_DL_TX_ARB_STATS_EN is defined.
module pcie_dl_tx_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = 3,
   parameter int S_COUNT = 3,
   parameter logic [S_COUNT-1:0] DLLP_MASK = 'b110,
   parameter int STARVE_LIMIT = 8,
   localparam int IW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
   input logic clk_i,
   input logic rst_ni,
   pcie_dl_tx_arb_if.slave bus,
   input logic link_up_i,
   output logic [IW-1:0] grant_o,
   output logic grant_vld_o
`ifdef PCIE_DL_TX_ARB_STATS_EN
   ,
   output logic [S_COUNT*16-1:0] stat_pkt_cnt_o,
   output logic stat_starve_o
`endif
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_nxt;
   logic [S_COUNT-1:0] dllp_req, tlp_req, tlp_rot;
   logic [IW-1:0] dllp_idx, tlp_idx, win, rr_ptr;
   logic [7:0] starve;
   logic [DATA_WIDTH-1:0] data_s [S_COUNT];
   logic [KEEP_WIDTH-1:0] keep_s [S_COUNT];
   logic [USER_WIDTH-1:0] user_s [S_COUNT];
   logic go, force_tlp, pick_tlp, s_rdy, hs, last_hs;

   for (genvar i = 0; i < S_COUNT; i++) begin : g_split
      assign data_s[i] = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign keep_s[i] = bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
      assign user_s[i] = bus.s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
   end

   assign dllp_req = bus.s_axis_tvalid & DLLP_MASK;
   assign tlp_req = bus.s_axis_tvalid & ~DLLP_MASK & {S_COUNT{link_up_i}};
   // Rotate so bit 0 is the port at rr_ptr; the lowest set bit is then the round-robin winner.
   assign tlp_rot = S_COUNT'({tlp_req, tlp_req} >> rr_ptr);

   always_comb begin
      dllp_idx = '0;
      tlp_idx = '0;
      for (int k = S_COUNT - 1; k >= 0; k--) begin
         if (dllp_req[k]) dllp_idx = IW'(k);
         if (tlp_rot[k]) tlp_idx = IW'((int'(rr_ptr) + k) % S_COUNT);
      end
   end

   assign force_tlp = (starve == 8'(STARVE_LIMIT)) && |tlp_req;
   assign pick_tlp = force_tlp || (!(|dllp_req) && |tlp_req);
   assign win = pick_tlp ? tlp_idx : dllp_idx;
   assign go = (state == IDLE) && |(dllp_req | tlp_req);
   // The input beat is taken only when the output register is empty or draining this cycle.
   assign s_rdy = (state == BUSY) && (!bus.m_axis_tvalid || bus.m_axis_tready);
   assign hs = s_rdy && bus.s_axis_tvalid[grant_o];
   assign last_hs = hs && bus.s_axis_tlast[grant_o];
   assign bus.s_axis_tready = s_rdy ? (S_COUNT'(1) << grant_o) : '0;
   assign grant_vld_o = (state == BUSY);

   always_comb begin
      state_nxt = state;
      if (go) state_nxt = BUSY;
      else if (state == BUSY && last_hs) state_nxt = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         grant_o <= '0;
         rr_ptr <= '0;
         starve <= '0;
         bus.m_axis_tdata <= '0;
         bus.m_axis_tkeep <= '0;
         bus.m_axis_tuser <= '0;
         bus.m_axis_tlast <= 1'b0;
         bus.m_axis_tvalid <= 1'b0;
      end else begin
         state <= state_nxt;
         if (go) begin
            grant_o <= win;
            if (pick_tlp) begin
               rr_ptr <= IW'((int'(tlp_idx) + 1) % S_COUNT);
               starve <= '0;
            end else if (|tlp_req && starve < 8'(STARVE_LIMIT)) begin
               starve <= starve + 8'd1;
            end
         end
         if (hs) begin
            bus.m_axis_tdata <= data_s[grant_o];
            bus.m_axis_tkeep <= keep_s[grant_o];
            bus.m_axis_tuser <= user_s[grant_o];
            bus.m_axis_tlast <= bus.s_axis_tlast[grant_o];
            bus.m_axis_tvalid <= 1'b1;
         end else if (bus.m_axis_tready) begin
            bus.m_axis_tvalid <= 1'b0;
         end
      end
   end

`ifdef PCIE_DL_TX_ARB_STATS_EN
   logic [15:0] pkt_cnt [S_COUNT];

   for (genvar i = 0; i < S_COUNT; i++) begin : g_stat
      assign stat_pkt_cnt_o[i*16 +: 16] = pkt_cnt[i];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_starve_o <= 1'b0;
         for (int k = 0; k < S_COUNT; k++) pkt_cnt[k] <= '0;
      end else begin
         stat_starve_o <= go && force_tlp;
         if (last_hs) pkt_cnt[grant_o] <= pkt_cnt[grant_o] + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pcie_dl_tx_arb.sv
// tb_pcie_dl_tx_arb: scoreboard bench for pcie_dl_tx_arb (3-port DLLP/TLP mix and 4-port round-robin)
module tb_pcie_dl_tx_arb;
   localparam int DW = 32;
   localparam int KW = 4;
   localparam int UW = 3;

   typedef struct packed {logic [31:0] d; logic l; logic [2:0] u;} beat_t;
   typedef struct packed {logic [1:0] g; logic f;} gnt_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic link_a = 1'b1;
   logic link_b = 1'b1;
   logic [1:0] grant_a, grant_b;
   logic gvld_a, gvld_b;
   int checks = 0;
   int errors = 0;
   int exp_cnt_a [3] = '{0, 0, 0};
   int exp_cnt_b [4] = '{0, 0, 0, 0};
   beat_t qa[$], qb[$];
   gnt_t ga[$], gb[$];
   bit mon_en = 0;
   bit bub_en = 0;
   bit bp_mode = 0;

   always #5 clk = ~clk;

   pcie_dl_tx_arb_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .S_COUNT(3)) ifa ();
   pcie_dl_tx_arb_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .S_COUNT(4)) ifb ();

`ifdef PCIE_DL_TX_ARB_STATS_EN
   logic [47:0] cnt_a;
   logic [63:0] cnt_b;
   logic starve_a, starve_b;
`endif

   pcie_dl_tx_arb #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .S_COUNT(3),
      .DLLP_MASK(3'b110), .STARVE_LIMIT(2)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .bus(ifa), .link_up_i(link_a),
      .grant_o(grant_a), .grant_vld_o(gvld_a)
`ifdef PCIE_DL_TX_ARB_STATS_EN
      , .stat_pkt_cnt_o(cnt_a), .stat_starve_o(starve_a)
`endif
   );

   pcie_dl_tx_arb #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .S_COUNT(4),
      .DLLP_MASK(4'b1000), .STARVE_LIMIT(8)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .bus(ifb), .link_up_i(link_b),
      .grant_o(grant_b), .grant_vld_o(gvld_b)
`ifdef PCIE_DL_TX_ARB_STATS_EN
      , .stat_pkt_cnt_o(cnt_b), .stat_starve_o(starve_b)
`endif
   );

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, x);
      end
   endtask

   task automatic miss(input string n);
      checks++;
      errors++;
      $display("FAIL %s: event observed/expired, required the opposite", n);
   endtask

   function automatic logic [31:0] mk(input int p, input int k, input int b);
      return {8'hA5, p[7:0], k[7:0], b[7:0]};
   endfunction

   task automatic exp_a(input int p, input int k, input int n, input logic f);
      ga.push_back(gnt_t'{p[1:0], f});
      for (int b = 0; b < n; b++) qa.push_back(beat_t'{mk(p, k, b), b == n - 1, p[2:0]});
      exp_cnt_a[p]++;
   endtask

   task automatic exp_b(input int p, input int k);
      gb.push_back(gnt_t'{p[1:0], 1'b0});
      qb.push_back(beat_t'{mk(p, k, 0), 1'b1, p[2:0]});
      exp_cnt_b[p]++;
   endtask

   task automatic drive_a(input int p, input int k, input int b, input logic l);
      ifa.s_axis_tdata[p*DW +: DW] = mk(p, k, b);
      ifa.s_axis_tkeep[p*KW +: KW] = '1;
      ifa.s_axis_tuser[p*UW +: UW] = p[2:0];
      ifa.s_axis_tlast[p] = l;
      ifa.s_axis_tvalid[p] = 1'b1;
   endtask

   task automatic send_a(input int p, input int k, input int n);
      for (int b = 0; b < n; b++) begin
         int t;
         bit acc;
         t = 0;
         acc = 0;
         drive_a(p, k, b, b == n - 1);
         while (!acc && t < 300) begin
            #1;
            acc = ifa.s_axis_tready[p];
            @(negedge clk);
            t++;
         end
         if (!acc) miss("a_accept_timeout");
      end
      ifa.s_axis_tvalid[p] = 1'b0;
      ifa.s_axis_tlast[p] = 1'b0;
   endtask

   task automatic send_b(input int p, input int k);
      int t;
      bit acc;
      t = 0;
      acc = 0;
      ifb.s_axis_tdata[p*DW +: DW] = mk(p, k, 0);
      ifb.s_axis_tkeep[p*KW +: KW] = '1;
      ifb.s_axis_tuser[p*UW +: UW] = p[2:0];
      ifb.s_axis_tlast[p] = 1'b1;
      ifb.s_axis_tvalid[p] = 1'b1;
      while (!acc && t < 300) begin
         #1;
         acc = ifb.s_axis_tready[p];
         @(negedge clk);
         t++;
      end
      if (!acc) miss("b_accept_timeout");
      ifb.s_axis_tvalid[p] = 1'b0;
      ifb.s_axis_tlast[p] = 1'b0;
   endtask

   always @(negedge clk) ifa.m_axis_tready = bp_mode ? !ifa.m_axis_tready : 1'b1;

   beat_t ea, eb;
   gnt_t fa, fb;
   logic prev_a = 1'b0, prev_b = 1'b0, hold_v = 1'b0, bub = 1'b0;
   logic [31:0] hold_d;

   always @(negedge clk) begin
      #2;
      if (mon_en) begin
         if (hold_v) chk("a_stall_hold", {ifa.m_axis_tvalid, ifa.m_axis_tdata}, {1'b1, hold_d});
         if (bub) chk("a_bubble", ifa.m_axis_tvalid, 0);
         hold_v = ifa.m_axis_tvalid && !ifa.m_axis_tready;
         hold_d = ifa.m_axis_tdata;
         bub = 1'b0;
         if (ifa.m_axis_tvalid && ifa.m_axis_tready) begin
            if (qa.size() == 0) miss("a_unexpected_beat");
            else begin
               ea = qa.pop_front();
               chk("a_beat", {ifa.m_axis_tdata, ifa.m_axis_tlast, ifa.m_axis_tuser, ifa.m_axis_tkeep}, {ea, 4'hF});
            end
            bub = bub_en && ifa.m_axis_tlast;
         end
         if (gvld_a && !prev_a) begin
            if (ga.size() == 0) miss("a_unexpected_grant");
            else begin
               fa = ga.pop_front();
`ifdef PCIE_DL_TX_ARB_STATS_EN
               chk("a_grant", {grant_a, starve_a}, {fa.g, fa.f});
`else
               chk("a_grant", grant_a, fa.g);
`endif
            end
         end
         prev_a = gvld_a;
      end
   end

   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (ifb.m_axis_tvalid) begin
            if (qb.size() == 0) miss("b_unexpected_beat");
            else begin
               eb = qb.pop_front();
               chk("b_beat", {ifb.m_axis_tdata, ifb.m_axis_tlast, ifb.m_axis_tuser}, eb);
            end
         end
         if (gvld_b && !prev_b) begin
            if (gb.size() == 0) miss("b_unexpected_grant");
            else begin
               fb = gb.pop_front();
`ifdef PCIE_DL_TX_ARB_STATS_EN
               chk("b_grant", {grant_b, starve_b}, {fb.g, fb.f});
`else
               chk("b_grant", grant_b, fb.g);
`endif
            end
         end
         prev_b = gvld_b;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic bad;
      ifa.s_axis_tdata = '0;
      ifa.s_axis_tkeep = '0;
      ifa.s_axis_tvalid = '0;
      ifa.s_axis_tlast = '0;
      ifa.s_axis_tuser = '0;
      ifa.m_axis_tready = 1'b1;
      ifb.s_axis_tdata = '0;
      ifb.s_axis_tkeep = '0;
      ifb.s_axis_tvalid = '0;
      ifb.s_axis_tlast = '0;
      ifb.s_axis_tuser = '0;
      ifb.m_axis_tready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_out", {ifa.m_axis_tvalid, ifa.m_axis_tdata, ifa.m_axis_tkeep, ifa.m_axis_tlast, ifa.m_axis_tuser}, 0);
      chk("reset_grant", {gvld_a, grant_a, ifa.s_axis_tready, gvld_b, grant_b, ifb.s_axis_tready}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      drive_a(2, 0, 1, 1'b0);
      repeat (3) @(negedge clk);
      chk("pre_reset_stream", {gvld_a, grant_a, ifa.m_axis_tvalid}, {1'b1, 2'd2, 1'b1});
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_out", {ifa.m_axis_tvalid, ifa.m_axis_tdata, ifa.m_axis_tkeep, ifa.m_axis_tlast, ifa.m_axis_tuser}, 0);
      chk("async_reset_grant", {gvld_a, grant_a, ifa.s_axis_tready}, 0);
      ifa.s_axis_tvalid = '0;
      ifa.s_axis_tlast = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1;
      bub_en = 1;
      exp_a(1, 1, 2, 1'b0);
      exp_a(2, 1, 2, 1'b0);
      exp_a(0, 1, 4, 1'b1);
      fork
         send_a(1, 1, 2);
         send_a(2, 1, 2);
         send_a(0, 1, 4);
      join
      repeat (4) @(negedge clk);
      exp_a(1, 2, 1, 1'b0);
      exp_a(1, 3, 1, 1'b0);
      exp_a(0, 2, 2, 1'b1);
      exp_a(1, 4, 1, 1'b0);
      exp_a(1, 5, 1, 1'b0);
      exp_a(0, 3, 2, 1'b1);
      fork
         begin
            for (int k = 2; k < 6; k++) send_a(1, k, 1);
         end
         begin
            send_a(0, 2, 2);
            send_a(0, 3, 2);
         end
      join
      repeat (4) @(negedge clk);
      link_a = 1'b0;
      exp_a(1, 6, 1, 1'b0);
      drive_a(0, 4, 0, 1'b1);
      send_a(1, 6, 1);
      bad = 1'b0;
      repeat (10) begin
         #1 bad = bad | ifa.s_axis_tready[0] | (gvld_a && grant_a == 2'd0);
         @(negedge clk);
      end
      chk("link_down_block", bad, 0);
      ifa.s_axis_tvalid[0] = 1'b0;
      link_a = 1'b1;
      exp_a(0, 4, 1, 1'b0);
      send_a(0, 4, 1);
      exp_a(0, 5, 4, 1'b0);
      fork
         send_a(0, 5, 4);
         begin
            for (int t = 0; t < 50 && !(gvld_a && grant_a == 2'd0); t++) @(negedge clk);
            link_a = 1'b0;
         end
      join
      drive_a(0, 6, 0, 1'b1);
      bad = 1'b0;
      repeat (10) begin
         #1 bad = bad | ifa.s_axis_tready[0] | gvld_a;
         @(negedge clk);
      end
      chk("link_drop_no_regrant", bad, 0);
      ifa.s_axis_tvalid[0] = 1'b0;
      link_a = 1'b1;
      exp_a(0, 6, 1, 1'b0);
      send_a(0, 6, 1);
      repeat (3) @(negedge clk);
      bub_en = 0;
      bp_mode = 1;
      exp_a(0, 7, 8, 1'b0);
      send_a(0, 7, 8);
      repeat (6) @(negedge clk);
      bp_mode = 0;
      for (int k = 0; k < 2; k++) for (int p = 0; p < 3; p++) exp_b(p, k);
      fork
         begin send_b(0, 0); send_b(0, 1); end
         begin send_b(1, 0); send_b(1, 1); end
         begin send_b(2, 0); send_b(2, 1); end
      join
      repeat (6) @(negedge clk);
      chk("a_beats_left", qa.size(), 0);
      chk("a_grants_left", ga.size(), 0);
      chk("b_beats_left", qb.size(), 0);
      chk("b_grants_left", gb.size(), 0);
`ifdef PCIE_DL_TX_ARB_STATS_EN
      for (int p = 0; p < 3; p++) chk("a_pkt_cnt", cnt_a[p*16 +: 16], exp_cnt_a[p]);
      for (int p = 0; p < 4; p++) chk("b_pkt_cnt", cnt_b[p*16 +: 16], exp_cnt_b[p]);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pcie_dl_tx_arb.md
Name: pcie_dl_tx_arb

Overview:
- Parametrised, packet-atomic transmit arbiter between the datalink sources and the PHY logical layer: DLLP generators (Ack/Nak, UpdateFC/InitFC) and one or more TLP retry/transmit streams.
- Two priority classes: strict priority for DLLP-class ports, round-robin among TLP-class ports.
- Starvation limiter guarantees TLP forward progress; TLP-class grants are gated by link state.
- Single registered output stage; replaces the generic 3-input mux in the datalink top.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 3, tuser width.
- S_COUNT, 3, number of input ports, 2..16.
- DLLP_MASK, 'b110, S_COUNT-bit mask; bit i=1 makes port i DLLP-class, 0 makes it TLP-class.
- STARVE_LIMIT, 8, consecutive DLLP packets allowed while a TLP port waits, 1..255.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  packed input data, port 0 in LSBs.
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  packed keep.
- s_axis_tvalid  in  S_COUNT  per-port valid.
- s_axis_tlast  in  S_COUNT  per-port last.
- s_axis_tuser  in  S_COUNT*USER_WIDTH  packed user.
- s_axis_tready  out  S_COUNT  per-port ready.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output keep.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output last.
- m_axis_tuser  out  USER_WIDTH  output user.
- m_axis_tready  in  1  output ready.
- link_up_i  in  1  DL_Active; low blocks new TLP-class grants.
- grant_o  out  max(1,$clog2(S_COUNT))  index of the currently granted port.
- grant_vld_o  out  1  a packet is currently granted.

Behaviour:
- Reset (rst_ni low, async): m_axis_tvalid=0, tdata/tkeep/tuser/tlast=0, s_axis_tready=0, grant_vld_o=0, grant_o=0, starvation counter=0, round-robin pointer=0.
- FSM states:
  - IDLE: evaluate requests each cycle.
  - BUSY: hold the grant.
- IDLE to BUSY: on any eligible request, registering the winner. Eligible means tvalid=1, and for TLP-class ports also link_up_i=1.
- BUSY to IDLE: on the cycle the granted port's tlast beat is accepted (s_valid & s_ready & s_last). There is no same-cycle regrant; one idle bubble between packets is required.
- Arbitration, evaluated in IDLE:
  - If the starvation counter == STARVE_LIMIT and any TLP request is eligible, pick a TLP port.
  - Else, if any DLLP request is present, pick the lowest-index DLLP port.
  - Else pick a TLP port.
  - TLP selection is round-robin: the first eligible TLP port at index >= rr_ptr, wrapping modulo S_COUNT. On a TLP grant, rr_ptr becomes granted index+1, wrapping to 0.
- Starvation counter (8 bits):
  - +1 on a DLLP grant made while any TLP request is eligible.
  - Cleared on any TLP grant.
  - Saturates at STARVE_LIMIT.
  - Unchanged on a DLLP grant with no eligible TLP request.
- Handshake:
  - s_axis_tready[g] = BUSY & (g==grant) & (~m_axis_tvalid | m_axis_tready). All other ports have tready=0.
  - The output register loads on s handshake. m_axis_tvalid clears when m_axis_tready=1 and no new beat arrives.
  - Latency is 1 cycle input to output; full throughput while m_axis_tready=1.
  - Output holds stable while m_axis_tvalid & ~m_axis_tready (AXIS rule).
- Packet atomicity: no beat from another port appears between a granted packet's first beat and its tlast.
- Link down mid-packet: the granted TLP packet completes; only new TLP grants are blocked. DLLP-class ports are unaffected by link_up_i, so InitFC can pass before link up.
- A granted port dropping tvalid mid-packet simply stalls; the grant is held.
- grant_o/grant_vld_o update on the IDLE to BUSY register edge. grant_vld_o deasserts the cycle after the tlast handshake.

Optional Feature:
- Macro: PCIE_DL_TX_ARB_STATS_EN.
- Defined:
  - Adds output port stat_pkt_cnt_o [S_COUNT*16]: per-port 16-bit wrapping counters of accepted tlast beats.
  - Adds output stat_starve_o [1]: pulses 1 cycle when a grant is forced by the starvation limit.
  - Counters reset to 0.
- Undefined: neither port exists, and no counter logic is present.

Test Plan:
- Reset mid-packet: assert rst_ni low while port 2 streams beat 2 of 4 -> all outputs 0 immediately. After release, the first grant goes to the lowest-index eligible DLLP port.
- Priority: S_COUNT=3, DLLP_MASK='b110, ports 1 and 2 each present a 2-beat DLLP and port 0 a 4-beat TLP, link_up_i=1 -> order on output is port 1, port 2, port 0. Check 1-cycle bubble between packets and no interleaving.
- Starvation: STARVE_LIMIT=2, port 1 sends DLLPs continuously, port 0 TLP pending -> grant sequence 1,1,0,1,1,0. stat_starve_o pulses at each port-0 grant when the macro is defined.
- Round-robin: S_COUNT=4, DLLP_MASK='b1000, ports 0,1,2 hold continuous 1-beat TLPs -> grants 0,1,2,0,1,2.
- Link gating: link_up_i=0, port 0 TLP valid, port 1 DLLP valid -> only port 1 is granted and s_axis_tready[0] stays 0. Drop link_up_i during a 4-beat TLP -> all 4 beats are output, then no further TLP grant.
- Backpressure: toggle m_axis_tready 1010... during an 8-beat packet -> 8 beats out in order, data stable while stalled, no loss or duplication. With the stats macro defined, the port counter increments by 1.
